// File: rtl/camera_param_ctrl.sv
// Frame-synchronous camera parameter controller: button auto-repeat for the
// frustum magnitudes, a one-deep pose slot, and a single commit per frame at the start of vblank.
module camera_param_ctrl #(
  parameter int          INITIAL_DELAY = 500000,
  parameter int          REPEAT_CYCLES = 100000,
  parameter logic [7:0]  FAR_RESET     = 8'd17,
  parameter logic [7:0]  NEAR_RESET    = 8'd0,
  parameter logic [7:0]  MAG_MAX       = 8'd255,
  parameter logic [9:0]  ACTIVE_V      = 10'd720
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic [3:0]  change_in,
  input  logic        pose_valid_in,
  output logic        pose_ready_out,
  input  logic [15:0] ballx_in,
  input  logic [15:0] bally_in,
  input  logic [15:0] angle_in,
  output logic [15:0] ballx_out,
  output logic [15:0] bally_out,
  output logic [15:0] angle_out,
  output logic [7:0]  far_mag_out,
  output logic [7:0]  near_mag_out,
  output logic        frame_start_out
);

  typedef enum logic [1:0] {IDLE, FIRST, REPEAT} chan_state_t;

  localparam logic [19:0] FIRST_LAST  = 20'(INITIAL_DELAY - 1);
  localparam logic [19:0] REPEAT_LAST = 20'(REPEAT_CYCLES - 1);

  logic [1:0] step_up;
  logic [1:0] step_dn;

  // Channel 0 drives far_w from change_in[1:0], channel 1 drives near_w from change_in[3:2].
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic        up, dn, press;
      logic        dir_reg, dir_next;
      logic [19:0] cnt_reg, cnt_next;
      logic        su, sd;
      chan_state_t state_reg, state_next;

      assign up    = change_in[2*gi];
      assign dn    = change_in[2*gi+1];
      assign press = up ^ dn;
      assign step_up[gi] = su;
      assign step_dn[gi] = sd;

      always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          dir_reg   <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          dir_reg   <= dir_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dir_next   = dir_reg;
        su         = 1'b0;
        sd         = 1'b0;
        if (!press) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if ((state_reg != FIRST && state_reg != REPEAT) || up != dir_reg) begin
          // Fresh press, or a direction reversal while held.
          su         = up;
          sd         = dn;
          dir_next   = up;
          cnt_next   = '0;
          state_next = FIRST;
        end else if ((state_reg == FIRST && cnt_reg == FIRST_LAST) ||
                     (state_reg == REPEAT && cnt_reg == REPEAT_LAST)) begin
          su         = up;
          sd         = dn;
          cnt_next   = '0;
          state_next = REPEAT;
        end else begin
          cnt_next = cnt_reg + 20'd1;
        end
      end
    end
  endgenerate

  logic [7:0] far_w, near_w;
  logic       far_inc, far_dec, near_inc, near_dec;

  // far- takes priority when the two steps would cross over each other.
  assign far_inc  = step_up[0] && (far_w != MAG_MAX);
  assign far_dec  = step_dn[0] && (far_w != near_w);
  assign near_inc = step_up[1] && (near_w != far_w) && !(far_dec && far_w == near_w + 8'd1);
  assign near_dec = step_dn[1] && (near_w != 8'd0);

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      far_w  <= FAR_RESET;
      near_w <= NEAR_RESET;
    end else begin
      if (far_inc)       far_w <= far_w + 8'd1;
      else if (far_dec)  far_w <= far_w - 8'd1;
      if (near_inc)      near_w <= near_w + 8'd1;
      else if (near_dec) near_w <= near_w - 8'd1;
    end
  end

  logic        boundary;
  logic        pend_full;
  logic [15:0] pend_x, pend_y, pend_a;

  assign boundary = (hcount_in == 11'd0) && (vcount_in == ACTIVE_V);

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      pend_full       <= 1'b0;
      pose_ready_out  <= 1'b1;
      pend_x          <= '0;
      pend_y          <= '0;
      pend_a          <= '0;
      ballx_out       <= '0;
      bally_out       <= '0;
      angle_out       <= '0;
      far_mag_out     <= FAR_RESET;
      near_mag_out    <= NEAR_RESET;
      frame_start_out <= 1'b0;
    end else begin
      frame_start_out <= boundary;
      if (boundary) begin
        far_mag_out  <= far_w;
        near_mag_out <= near_w;
      end
      // A pose accepted in the boundary cycle only fills the slot; it commits next frame.
      if (boundary && pend_full) begin
        ballx_out      <= pend_x;
        bally_out      <= pend_y;
        angle_out      <= pend_a;
        pend_full      <= 1'b0;
        pose_ready_out <= 1'b1;
      end else if (pose_valid_in && pose_ready_out) begin
        pend_x         <= ballx_in;
        pend_y         <= bally_in;
        pend_a         <= angle_in;
        pend_full      <= 1'b1;
        pose_ready_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_camera_param_ctrl.sv
// Randomized bench for camera_param_ctrl: random button holds, pose offers and
// resets, checked every cycle against a hold-age based reference model.
module tb_camera_param_ctrl;

  localparam int ID    = 20;
  localparam int RC    = 5;
  localparam int MAXV  = 40;
  localparam int AV    = 10;
  localparam int HTOT  = 8;
  localparam int VTOT  = 13;
  localparam int NCYC  = 6000;

  logic        clk = 1'b0;
  logic        rst_in;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [3:0]  change;
  logic        pose_valid;
  logic        pose_ready;
  logic [15:0] ballx_in, bally_in, angle_in;
  logic [15:0] ballx_out, bally_out, angle_out;
  logic [7:0]  far_mag, near_mag;
  logic        frame_start;

  camera_param_ctrl #(
    .INITIAL_DELAY(ID), .REPEAT_CYCLES(RC), .FAR_RESET(8'd17), .NEAR_RESET(8'd0),
    .MAG_MAX(8'(MAXV)), .ACTIVE_V(10'(AV))
  ) dut (
    .pixel_clk_in(clk), .rst_in(rst_in), .hcount_in(hcount), .vcount_in(vcount),
    .change_in(change), .pose_valid_in(pose_valid), .pose_ready_out(pose_ready),
    .ballx_in(ballx_in), .bally_in(bally_in), .angle_in(angle_in),
    .ballx_out(ballx_out), .bally_out(bally_out), .angle_out(angle_out),
    .far_mag_out(far_mag), .near_mag_out(near_mag), .frame_start_out(frame_start)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_value(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int m_far, m_near, m_far_o, m_near_o, m_bx, m_by, m_ba, m_px, m_py, m_pa;
  bit m_pend, m_fs;
  bit m_held [2];
  bit m_dir  [2];
  int m_age  [2];

  task automatic model_reset();
    m_far = 17; m_near = 0; m_far_o = 17; m_near_o = 0;
    m_bx = 0; m_by = 0; m_ba = 0; m_pend = 0; m_fs = 0;
    for (int c = 0; c < 2; c++) begin
      m_held[c] = 0; m_age[c] = 0; m_dir[c] = 0;
    end
  endtask

  task automatic model_edge();
    bit su [2];
    bit sd [2];
    bit fi, fd, ni, nd, bnd;
    for (int c = 0; c < 2; c++) begin
      bit u, d;
      u = change[2*c];
      d = change[2*c+1];
      su[c] = 0;
      sd[c] = 0;
      if (u == d) begin
        m_held[c] = 0;
      end else begin
        if (!m_held[c] || m_dir[c] != u) begin
          m_held[c] = 1; m_dir[c] = u; m_age[c] = 0;
        end else begin
          m_age[c]++;
        end
        if (m_age[c] == 0 || (m_age[c] >= ID && (m_age[c] - ID) % RC == 0)) begin
          su[c] = u; sd[c] = d;
        end
      end
    end
    fi = su[0] && m_far != MAXV;
    fd = sd[0] && m_far != m_near;
    ni = su[1] && m_near != m_far && !(fd && m_far == m_near + 1);
    nd = sd[1] && m_near != 0;
    bnd = (hcount == 0) && (vcount == AV);
    m_fs = bnd;
    if (bnd) begin
      m_far_o = m_far; m_near_o = m_near;
    end
    if (bnd && m_pend) begin
      m_bx = m_px; m_by = m_py; m_ba = m_pa; m_pend = 0;
    end else if (!m_pend && pose_valid) begin
      m_px = int'(ballx_in); m_py = int'(bally_in); m_pa = int'(angle_in); m_pend = 1;
    end
    m_far  = m_far + int'(fi) - int'(fd);
    m_near = m_near + int'(ni) - int'(nd);
  endtask

  task automatic compare_all();
    check_value("far_mag",     int'(far_mag),     m_far_o);
    check_value("near_mag",    int'(near_mag),    m_near_o);
    check_value("frame_start", int'(frame_start), int'(m_fs));
    check_value("pose_ready",  int'(pose_ready),  int'(!m_pend));
    check_value("ballx",       int'(ballx_out),   m_bx);
    check_value("bally",       int'(bally_out),   m_by);
    check_value("angle",       int'(angle_out),   m_ba);
  endtask

  int hold_left [2];

  initial begin
    rst_in = 1'b1; hcount = '0; vcount = 10'd3; change = '0; pose_valid = 1'b0;
    ballx_in = '0; bally_in = '0; angle_in = '0;
    hold_left[0] = 0; hold_left[1] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_in = 1'b0;
    #1 compare_all();

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      rst_in = 1'b0;
      if (int'(hcount) == HTOT - 1) begin
        hcount = '0;
        vcount = (int'(vcount) == VTOT - 1) ? 10'd0 : vcount + 10'd1;
      end else begin
        hcount = hcount + 11'd1;
      end
      for (int c = 0; c < 2; c++) begin
        if (hold_left[c] == 0) begin
          int r;
          logic [1:0] pat;
          r = int'($urandom_range(0, 9));
          pat = (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : (r == 7) ? 2'b11 : 2'b00;
          change[2*c +: 2] = pat;
          hold_left[c] = int'($urandom_range(1, 60));
        end
        hold_left[c]--;
      end
      pose_valid = ($urandom_range(0, 9) < 3);
      ballx_in = 16'($urandom);
      bally_in = 16'($urandom);
      angle_in = 16'($urandom_range(0, 359));
      if (cyc % 1500 == 777) begin
        // Asynchronous reset mid-frame, observed before any clock edge.
        rst_in = 1'b1;
        #1;
        model_reset();
        compare_all();
      end
      @(posedge clk);
      if (rst_in) model_reset();
      else        model_edge();
      #1 compare_all();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
